csr_trap_sequencer: RTL and testbench
=====================================

Name: csr_trap_sequencer

Overview:
- Owns the single access port of the machine-mode CSR register file.
- Arbitrates between core CSR instructions and hardware trap/mret sequencing.
- On a trap it writes mepc and mcause, updates mstatus, reads mtvec and issues a PC redirect.
- On mret it restores mstatus and redirects to mepc.
- Sits between the core pipeline and the CSR file. CSR file read data is registered and valid the cycle after a read strobe.

Parameters:
VECTORED_EN  1      1 = honour mtvec mode 1 (vectored) for interrupts; 0 = always direct
MPP_VAL      2'b11  value written to mstatus.MPP[12:11] on trap entry

Ports:
clk_i           in   1   clock
rst_i           in   1   reset, asynchronous, active-high
csr_req_i       in   1   core CSR access request
csr_we_i        in   1   1 = write, 0 = read
csr_addr_i      in   12  CSR address
csr_wdata_i     in   32  core write data
csr_gnt_o       out  1   core access accepted this cycle
csr_rvalid_o    out  1   core read data valid
csr_rdata_o     out  32  core read data
trap_req_i      in   1   trap request, held until acked
trap_cause_i    in   32  mcause value; bit31 = interrupt
trap_pc_i       in   32  faulting PC
trap_ack_o      out  1   trap accepted (1-cycle pulse)
mret_req_i      in   1   mret request, held until acked
mret_ack_o      out  1   mret accepted (1-cycle pulse)
stall_o         out  1   sequencer busy
redirect_valid_o out 1   registered 1-cycle PC redirect
redirect_pc_o   out  32  registered redirect target
csr_addr_o      out  32  to CSR file, zero-extended 12-bit address
csr_we_o        out  1   to CSR file write enable
csr_re_o        out  1   to CSR file read enable
csr_wdata_o     out  32  to CSR file write data
exc_mode_o      out  1   to CSR file en_except
csr_rdata_i     in   32  from CSR file data_out_o

Behaviour:
- Reset: state IDLE; latched cause/pc/mstatus = 0; redirect_valid_o = 0; redirect_pc_o = 0. All strobes, acks and exc_mode_o = 0.
- Reset mid-sequence aborts with no redirect. Reset is asynchronous.
- CSR-file outputs are combinational from state and latched registers. They are 0 in any state that makes no access.
- exc_mode_o = 1 only in T_VEC_RD; the CSR file blocks writes while it is high.
- IDLE priority: trap_req_i > mret_req_i > csr_req_i. A losing request gets no ack/gnt and must hold.
- Core write in IDLE: csr_gnt_o = 1 and csr_we_o = 1 in the same cycle, pass-through addr/data. Stay IDLE.
- Core read in IDLE: csr_gnt_o = 1 and csr_re_o = 1, then go to RD_WAIT.
- RD_WAIT: csr_rvalid_o = 1, csr_rdata_o = csr_rdata_i, return to IDLE. No new grant is given in RD_WAIT.
- Trap accept in IDLE (cycle 0): trap_ack_o = 1; latch cause and {pc[31:2], 2'b00}.
- Trap sequence:
  - T_EPC (c1): write 0x341 = latched pc.
  - T_CAUSE (c2): write 0x342 = cause.
  - T_ST_RD (c3): read 0x300.
  - T_ST_WR (c4): write 0x300 = rdata with bit7 <= rdata bit3, bit3 <= 0, [12:11] <= MPP_VAL.
  - T_VEC_RD (c5): read 0x305.
  - T_VEC_WAIT (c6): compute target, then go to IDLE.
- Trap target:
  - base = {mtvec[31:2], 2'b00}.
  - If VECTORED_EN and mtvec[1:0] == 1 and cause[31], target = base + (cause[30:0] << 2), truncated to 32 bits.
  - Otherwise target = base.
  - mtvec[1:0] >= 2 is treated as direct.
- redirect_valid_o = 1 in c7 only.
- Mret accept in IDLE (cycle 0): mret_ack_o = 1.
- Mret sequence:
  - M_ST_RD (c1): read 0x300.
  - M_ST_WR (c2): write 0x300 with bit3 <= rdata bit7, bit7 <= 1, [12:11] <= 0.
  - M_EPC_RD (c3): read 0x341.
  - M_EPC_WAIT (c4): go to IDLE.
- Mret redirect in c5: redirect_pc_o = {mepc[31:2], 2'b00}.
- stall_o = 1 in every state except IDLE and RD_WAIT.
- Requests arriving while busy are ignored until IDLE. A request may be accepted in the same cycle a redirect pulses.
- No back-to-back redirects: there are at least 5 cycles between redirect pulses.

Test Plan:
- Reset with all inputs high -> every output 0. After release, trap accepted on the first edge.
- Core write 0x305 = 0x8000_0100, then core read 0x305 -> gnt in the same cycle; rvalid one cycle later with rdata 0x8000_0100.
- Trap, mtvec 0x8000_0100, cause 0x0000_0002, pc 0x0000_1236 -> mepc 0x0000_1234, mcause 2. Redirect 0x8000_0100 exactly 7 cycles after ack; stall high c1..c6.
- Vectored interrupt, mtvec 0x8000_0101, cause 0x8000_0007, mstatus 0x0000_0008 -> redirect 0x8000_011C; mstatus becomes 0x0000_1880.
- Simultaneous trap + mret + csr_req -> only trap_ack_o. Mret accepted at the first IDLE after the redirect. Mret redirect = mepc; mstatus MIE restored from MPIE.
- rst_i pulsed in T_ST_RD -> state IDLE, no redirect pulse, no further CSR-file strobes.

Source files
------------

// File: rtl/csr_trap_sequencer.sv
// rtl/csr_trap_sequencer.sv - machine-mode CSR port owner: core access, trap entry and mret sequencing
// Grants the core single-cycle CSR access in IDLE, otherwise walks fixed trap/mret CSR sequences.
module csr_trap_sequencer #(
  parameter bit         VECTORED_EN = 1'b1,
  parameter logic [1:0] MPP_VAL     = 2'b11
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        csr_req_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic        csr_gnt_o,
  output logic        csr_rvalid_o,
  output logic [31:0] csr_rdata_o,
  input  logic        trap_req_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_pc_i,
  output logic        trap_ack_o,
  input  logic        mret_req_i,
  output logic        mret_ack_o,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] csr_addr_o,
  output logic        csr_we_o,
  output logic        csr_re_o,
  output logic [31:0] csr_wdata_o,
  output logic        exc_mode_o,
  input  logic [31:0] csr_rdata_i
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  typedef enum logic [3:0] {
    IDLE, RD_WAIT,
    T_EPC, T_CAUSE, T_ST_RD, T_ST_WR, T_VEC_RD, T_VEC_WAIT,
    M_ST_RD, M_ST_WR, M_EPC_RD, M_EPC_WAIT
  } state_e;

  state_e      state_q;
  logic [31:0] cause_q;
  logic [31:0] pc_q;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;

  logic        idle;
  logic        trap_take;
  logic        mret_take;
  logic        core_take;
  logic [11:0] addr12;
  logic [31:0] mstatus_trap;
  logic [31:0] mstatus_mret;
  logic [31:0] vec_base;
  logic [31:0] trap_target;

  // Acks are combinational so they land in the request cycle; masked while reset is asserted.
  assign idle      = (state_q == IDLE) && !rst_i;
  assign trap_take = idle && trap_req_i;
  assign mret_take = idle && !trap_req_i && mret_req_i;
  assign core_take = idle && !trap_req_i && !mret_req_i && csr_req_i;

  assign csr_gnt_o        = core_take;
  assign trap_ack_o       = trap_take;
  assign mret_ack_o       = mret_take;
  assign csr_rvalid_o     = (state_q == RD_WAIT);
  assign csr_rdata_o      = csr_rvalid_o ? csr_rdata_i : 32'd0;
  assign stall_o          = (state_q != IDLE) && (state_q != RD_WAIT);
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign csr_addr_o       = {20'd0, addr12};

  always_comb begin
    mstatus_trap        = csr_rdata_i;
    mstatus_trap[7]     = csr_rdata_i[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = MPP_VAL;
    mstatus_mret        = csr_rdata_i;
    mstatus_mret[3]     = csr_rdata_i[7];
    mstatus_mret[7]     = 1'b1;
    mstatus_mret[12:11] = 2'b00;
  end

  // mtvec modes 2 and 3 fall back to direct.
  assign vec_base    = {csr_rdata_i[31:2], 2'b00};
  assign trap_target = (VECTORED_EN && (csr_rdata_i[1:0] == 2'b01) && cause_q[31])
                     ? vec_base + {cause_q[29:0], 2'b00} : vec_base;

  always_comb begin
    addr12      = 12'd0;
    csr_we_o    = 1'b0;
    csr_re_o    = 1'b0;
    csr_wdata_o = 32'd0;
    exc_mode_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (core_take) begin
          addr12   = csr_addr_i;
          csr_we_o = csr_we_i;
          csr_re_o = !csr_we_i;
          if (csr_we_i) csr_wdata_o = csr_wdata_i;
        end
      end
      T_EPC:    begin addr12 = ADDR_MEPC;    csr_we_o = 1'b1; csr_wdata_o = pc_q;         end
      T_CAUSE:  begin addr12 = ADDR_MCAUSE;  csr_we_o = 1'b1; csr_wdata_o = cause_q;      end
      T_ST_RD:  begin addr12 = ADDR_MSTATUS; csr_re_o = 1'b1;                             end
      T_ST_WR:  begin addr12 = ADDR_MSTATUS; csr_we_o = 1'b1; csr_wdata_o = mstatus_trap; end
      T_VEC_RD: begin addr12 = ADDR_MTVEC;   csr_re_o = 1'b1; exc_mode_o = 1'b1;          end
      M_ST_RD:  begin addr12 = ADDR_MSTATUS; csr_re_o = 1'b1;                             end
      M_ST_WR:  begin addr12 = ADDR_MSTATUS; csr_we_o = 1'b1; csr_wdata_o = mstatus_mret; end
      M_EPC_RD: begin addr12 = ADDR_MEPC;    csr_re_o = 1'b1;                             end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      cause_q          <= 32'd0;
      pc_q             <= 32'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
    end else begin
      redirect_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trap_take) begin
            state_q <= T_EPC;
            cause_q <= trap_cause_i;
            pc_q    <= {trap_pc_i[31:2], 2'b00};
          end else if (mret_take) begin
            state_q <= M_ST_RD;
          end else if (core_take && !csr_we_i) begin
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT:  state_q <= IDLE;
        T_EPC:    state_q <= T_CAUSE;
        T_CAUSE:  state_q <= T_ST_RD;
        T_ST_RD:  state_q <= T_ST_WR;
        T_ST_WR:  state_q <= T_VEC_RD;
        T_VEC_RD: state_q <= T_VEC_WAIT;
        T_VEC_WAIT: begin
          state_q          <= IDLE;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= trap_target;
        end
        M_ST_RD:  state_q <= M_ST_WR;
        M_ST_WR:  state_q <= M_EPC_RD;
        M_EPC_RD: state_q <= M_EPC_WAIT;
        M_EPC_WAIT: begin
          state_q          <= IDLE;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= {csr_rdata_i[31:2], 2'b00};
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// tb/tb_csr_trap_sequencer.sv - scoreboard bench for csr_trap_sequencer with a registered CSR file model
module tb_csr_trap_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        csr_req_i, csr_we_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic        csr_gnt_o, csr_rvalid_o;
  logic [31:0] csr_rdata_o;
  logic        trap_req_i;
  logic [31:0] trap_cause_i, trap_pc_i;
  logic        trap_ack_o, mret_req_i, mret_ack_o, stall_o, redirect_valid_o;
  logic [31:0] redirect_pc_o, csr_addr_o, csr_wdata_o, csr_rdata_i;
  logic        csr_we_o, csr_re_o, exc_mode_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_redir_q[$];
  logic [31:0] exp_rd_q[$];

  logic [31:0] csr_mem [0:4095] = '{default: 32'd0};
  logic [31:0] csr_rdata_q = 32'd0;

  always #5 clk_i = ~clk_i;

  csr_trap_sequencer #(.VECTORED_EN(1'b1), .MPP_VAL(2'b11)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .csr_req_i(csr_req_i), .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
    .csr_gnt_o(csr_gnt_o), .csr_rvalid_o(csr_rvalid_o), .csr_rdata_o(csr_rdata_o),
    .trap_req_i(trap_req_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i), .trap_ack_o(trap_ack_o),
    .mret_req_i(mret_req_i), .mret_ack_o(mret_ack_o), .stall_o(stall_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .csr_addr_o(csr_addr_o), .csr_we_o(csr_we_o), .csr_re_o(csr_re_o), .csr_wdata_o(csr_wdata_o),
    .exc_mode_o(exc_mode_o), .csr_rdata_i(csr_rdata_i)
  );

  // CSR file: writes blocked in exception mode, read data registered one cycle.
  always @(posedge clk_i) begin
    if (csr_we_o && !exc_mode_o) csr_mem[csr_addr_o[11:0]] <= csr_wdata_o;
    if (csr_re_o) csr_rdata_q <= csr_mem[csr_addr_o[11:0]];
  end
  assign csr_rdata_i = csr_rdata_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && redirect_valid_o) begin
      if (exp_redir_q.size() == 0) check("redir_spurious", 32'(redirect_valid_o), 32'd0);
      else check("redir_pc", redirect_pc_o, exp_redir_q.pop_front());
    end
    if (!rst_i && csr_rvalid_o) begin
      if (exp_rd_q.size() == 0) check("rvalid_spurious", 32'(csr_rvalid_o), 32'd0);
      else check("rdata", csr_rdata_o, exp_rd_q.pop_front());
    end
  end

  task automatic check_all_zero(input string tag);
    check(tag, {23'd0, csr_gnt_o, csr_rvalid_o, trap_ack_o, mret_ack_o, stall_o,
                redirect_valid_o, csr_we_o, csr_re_o, exc_mode_o}, 32'd0);
    check({tag, "_bus"}, csr_addr_o | csr_wdata_o | csr_rdata_o | redirect_pc_o, 32'd0);
  endtask

  task automatic core_wr(input logic [11:0] addr, input logic [31:0] data);
    csr_req_i = 1'b1; csr_we_i = 1'b1; csr_addr_i = addr; csr_wdata_i = data;
    @(negedge clk_i);
    check("wr_gnt", 32'({csr_gnt_o, csr_we_o}), 32'd3);
    check("wr_addr", csr_addr_o, {20'd0, addr});
    check("wr_data", csr_wdata_o, data);
    tick();
    csr_req_i = 1'b0;
  endtask

  // Starts in the request cycle (c0) and returns at the redirect cycle (c7) after sampling.
  task automatic run_trap(input logic [31:0] exp_target, input bit keep_others);
    exp_redir_q.push_back(exp_target);
    @(negedge clk_i);
    check("c0_trap_ack", 32'(trap_ack_o), 32'd1);
    check("c0_others", 32'({mret_ack_o, csr_gnt_o}), 32'd0);
    tick();
    trap_req_i = 1'b0;
    if (!keep_others) begin
      mret_req_i = 1'b0;
      csr_req_i  = 1'b0;
    end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_i);
      check("busy_stall", 32'(stall_o), 32'd1);
      check("busy_no_ack", 32'({mret_ack_o, csr_gnt_o, redirect_valid_o}), 32'd0);
      check("exc_mode", 32'(exc_mode_o), 32'(c == 5));
      tick();
    end
    @(negedge clk_i);
    check("c7_redirect", 32'(redirect_valid_o), 32'd1);
    check("c7_stall", 32'(stall_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every input high
    rst_i = 1'b1;
    csr_req_i = 1'b1; csr_we_i = 1'b1; csr_addr_i = '1; csr_wdata_i = '1;
    trap_req_i = 1'b1; trap_cause_i = '1; trap_pc_i = '1; mret_req_i = 1'b1;
    @(negedge clk_i);
    check_all_zero("reset_outputs");
    tick();
    rst_i = 1'b0;
    run_trap(32'h0000_0000, 1'b0);
    tick();
    check("t1_mepc", csr_mem[12'h341], 32'hFFFF_FFFC);
    check("t1_mstatus", csr_mem[12'h300], 32'h0000_1800);

    // Core write then read of mtvec, request held through RD_WAIT
    core_wr(12'h305, 32'h8000_0100);
    csr_req_i = 1'b1; csr_we_i = 1'b0; csr_addr_i = 12'h305;
    exp_rd_q.push_back(32'h8000_0100);
    @(negedge clk_i);
    check("rd_gnt", 32'({csr_gnt_o, csr_re_o, csr_we_o, csr_rvalid_o}), 32'b1100);
    tick();
    @(negedge clk_i);
    check("rdwait_rvalid", 32'(csr_rvalid_o), 32'd1);
    check("rdwait_no_gnt", 32'({csr_gnt_o, csr_re_o, stall_o}), 32'd0);
    tick();
    csr_req_i = 1'b0;

    // Direct exception trap
    trap_cause_i = 32'h0000_0002; trap_pc_i = 32'h0000_1236; trap_req_i = 1'b1;
    run_trap(32'h8000_0100, 1'b0);
    tick();
    check("t3_mepc", csr_mem[12'h341], 32'h0000_1234);
    check("t3_mcause", csr_mem[12'h342], 32'h0000_0002);

    // Vectored interrupt
    core_wr(12'h305, 32'h8000_0101);
    core_wr(12'h300, 32'h0000_0008);
    trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h0000_2000; trap_req_i = 1'b1;
    run_trap(32'h8000_011C, 1'b0);
    tick();
    check("t4_mstatus", csr_mem[12'h300], 32'h0000_1880);
    check("t4_mcause", csr_mem[12'h342], 32'h8000_0007);

    // Trap + mret + core read all at once; mret then core read follow in priority order
    core_wr(12'h300, 32'h0000_0008);
    trap_cause_i = 32'h0000_000B; trap_pc_i = 32'h0000_3003; trap_req_i = 1'b1;
    mret_req_i = 1'b1; csr_req_i = 1'b1; csr_we_i = 1'b0; csr_addr_i = 12'h342;
    run_trap(32'h8000_0100, 1'b1);
    check("c7_mret_ack", 32'({mret_ack_o, csr_gnt_o}), 32'b10);
    exp_redir_q.push_back(32'h0000_3000);
    tick();
    mret_req_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_i);
      check("mret_busy", 32'({stall_o, csr_gnt_o, redirect_valid_o}), 32'b100);
      tick();
    end
    exp_rd_q.push_back(32'h0000_000B);
    @(negedge clk_i);
    check("m5_redirect_gnt", 32'({redirect_valid_o, stall_o, csr_gnt_o, csr_re_o}), 32'b1011);
    tick();
    csr_req_i = 1'b0;
    @(negedge clk_i);
    tick();
    check("t5_mstatus", csr_mem[12'h300], 32'h0000_0088);
    check("t5_mepc", csr_mem[12'h341], 32'h0000_3000);

    // Reset in T_ST_RD aborts the trap
    trap_cause_i = 32'h0000_0001; trap_pc_i = 32'h0000_4000; trap_req_i = 1'b1;
    @(negedge clk_i);
    check("t6_ack", 32'(trap_ack_o), 32'd1);
    tick();
    trap_req_i = 1'b0;
    tick();
    tick();
    @(negedge clk_i);
    check("t6_st_rd", {19'd0, csr_re_o, csr_addr_o[11:0]}, {19'd0, 1'b1, 12'h300});
    #2 rst_i = 1'b1;
    #1 check_all_zero("t6_async_reset");
    tick();
    rst_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      check("t6_quiet", 32'({csr_we_o, csr_re_o, exc_mode_o, redirect_valid_o, stall_o}), 32'd0);
      tick();
    end
    check("t6_mstatus_kept", csr_mem[12'h300], 32'h0000_0088);
    check("t6_mcause", csr_mem[12'h342], 32'h0000_0001);

    check("redir_q_empty", exp_redir_q.size(), 32'd0);
    check("rd_q_empty", exp_rd_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
